// File: rtl/local_port_rx_if.sv
// ---------------------------------------------------------------------------
// local_port_rx_if
// Groups the signals between a router output port, the local receive block
// and the word consumer.
//   in_data    [FLIT_W]    flit offered by the router
//   write_req  [1]         router offers in_data this cycle
//   full       [1]         backpressure to the router
//   word_out   [FLIT_W*FPW] assembled word, first flit in the MSBs
//   word_valid [1]         word_out holds a complete word
//   word_ready [1]         consumer accepts word_out
//   drop_err   [1]         sticky: a write was attempted while full
//   fifo_count [log2(DEPTH)+1] receive FIFO occupancy
// modport master: router/consumer side.  modport slave: the receive block.
// ---------------------------------------------------------------------------
interface local_port_rx_if #(
  parameter int FLIT_W = 4,
  parameter int DEPTH  = 4,
  parameter int FPW    = 4
);
  localparam int W  = FLIT_W * FPW;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [FLIT_W-1:0] in_data;
  logic              write_req;
  logic              full;
  logic [W-1:0]      word_out;
  logic              word_valid;
  logic              word_ready;
  logic              drop_err;
  logic [CW-1:0]     fifo_count;

  modport master (
    output in_data, write_req, word_ready,
    input  full, word_out, word_valid, drop_err, fifo_count
  );

  modport slave (
    input  in_data, write_req, word_ready,
    output full, word_out, word_valid, drop_err, fifo_count
  );
endinterface

// File: rtl/local_port_rx.sv
// ---------------------------------------------------------------------------
// local_port_rx
// Receives flits from a router output port into a small FIFO and assembles
// FPW consecutive flits into one word (first flit in the MSBs), handed to the
// consumer with a valid/ready handshake.
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : local_port_rx_if.slave (flit input, word output, status)
// ---------------------------------------------------------------------------
module local_port_rx #(
  parameter int FLIT_W = 4,
  parameter int DEPTH  = 4,
  parameter int FPW    = 4
) (
  input  logic           clk,
  input  logic           reset,
  local_port_rx_if.slave bus
);
  localparam int W  = FLIT_W * FPW;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = (FPW > 1) ? $clog2(FPW) : 1;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  // FIFO storage and pointers
  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Assembler state
  logic [0:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [W-1:0]      word_q, word_d;
  logic              valid_q, valid_d;
  logic              drop_q, drop_d;

  logic              full_w;
  logic              push;
  logic              pop;
  logic [FLIT_W-1:0] rd_data;

  // full comes only from the registered count, so write_req never reaches it.
  assign full_w  = (count_q == CW'(DEPTH));
  assign push    = bus.write_req & ~full_w;
  // Pops are gated by the registered count, which gives the one-edge
  // write-to-read separation without any bypass path.
  assign pop     = (state_q == COLLECT) && (count_q != '0);
  assign rd_data = mem_q[rd_ptr_q];

  // Storage has no reset: under reset the pointers and count are held at
  // zero, so any slot written there is never counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    valid_d = valid_q;
    drop_d  = drop_q | (bus.write_req & full_w);

    if (state_q == HOLD) begin
      // word_ready only matters here, so it is ignored while not valid.
      if (bus.word_ready) begin
        state_d = COLLECT;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    end else if (pop) begin
      // Slot 0 lands in the MSBs; an empty FIFO leaves idx and the
      // partial word untouched.
      for (int s = 0; s < FPW; s++) begin
        if (idx_q == IW'(s)) begin
          word_d[(FPW-1-s)*FLIT_W +: FLIT_W] = rd_data;
        end
      end
      if (idx_q == IW'(FPW-1)) begin
        state_d = HOLD;
        idx_d   = '0;
        valid_d = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= COLLECT;
      idx_q    <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.full       = full_w;
  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.drop_err   = drop_q;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_local_port_rx.sv
// ---------------------------------------------------------------------------
// tb_local_port_rx
// Self-checking bench for local_port_rx.  A reference model watches the flit
// side and queues every expected word; a monitor pops and compares each word
// as the consumer accepts it.  Directed scenarios plus a randomized run.
// ---------------------------------------------------------------------------
module tb_local_port_rx;
  localparam int FLIT_W = 4;
  localparam int DEPTH  = 4;
  localparam int FPW    = 4;
  localparam int W      = FLIT_W * FPW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  local_port_rx_if #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .FPW(FPW)) bus ();

  local_port_rx #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .FPW(FPW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_words  = 0;

  logic [FLIT_W-1:0] flit_m [$];
  logic [W-1:0]      exp_q  [$];
  logic              drop_m = 1'b0;
  logic [W-1:0]      wm;
  bit                rnd_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every flit offered while not full and out of reset is
  // accepted; each group of FPW accepted flits forms one word, first in MSBs.
  always @(negedge clk) begin
    if (!reset) begin
      flit_m.delete();
      exp_q.delete();
      drop_m = 1'b0;
    end
    check("drop_err", 32'(bus.drop_err), 32'(drop_m));
    if (reset && bus.write_req) begin
      if (bus.full) begin
        drop_m = 1'b1;
      end else begin
        flit_m.push_back(bus.in_data);
        if (flit_m.size() == FPW) begin
          wm = '0;
          for (int i = 0; i < FPW; i++) wm = (wm << FLIT_W) | W'(flit_m[i]);
          exp_q.push_back(wm);
          flit_m.delete();
          $display("model: expect word 0x%04h", wm);
        end
      end
    end
  end

  // Monitor: invariants every cycle, hold stability, word scoreboard.
  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic [W-1:0] pw = '0;
  logic [W-1:0] got_w;
  always @(negedge clk) begin
    check("count_bound", 32'(bus.fifo_count <= DEPTH), 32'd1);
    check("full_decode", 32'(bus.full), 32'(bus.fifo_count == DEPTH));
    if (reset && pv && !pr) begin
      check("hold_valid", 32'(bus.word_valid), 32'd1);
      check("hold_word", 32'(bus.word_out), 32'(pw));
    end
    if (bus.word_valid && bus.word_ready) begin
      check("exp_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        got_w = exp_q.pop_front();
        check("word", 32'(bus.word_out), 32'(got_w));
        n_words++;
        $display("monitor: word 0x%04h accepted (expected 0x%04h)", bus.word_out, got_w);
      end
    end
    pv = reset & bus.word_valid;
    pr = bus.word_ready;
    pw = bus.word_out;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) bus.word_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer one flit, waiting (write_req low) while full.
  task automatic send(input logic [FLIT_W-1:0] v);
    int n = 0;
    while (bus.full && n < 200) begin
      bus.write_req = 1'b0;
      step();
      n++;
    end
    if (n >= 200) check("full_timeout", 32'(bus.full), 32'd0);
    bus.write_req = 1'b1;
    bus.in_data   = v;
    step();
    bus.write_req = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    step();
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!bus.word_valid && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(bus.word_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int words0;

  initial begin
    bus.in_data    = '0;
    bus.write_req  = 1'b0;
    bus.word_ready = 1'b0;
    reset          = 1'b0;
    @(posedge clk);
    #1;
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_valid", 32'(bus.word_valid), 32'd0);
    check("rst_word", 32'(bus.word_out), 32'd0);
    check("rst_drop", 32'(bus.drop_err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Basic word and latency
    bus.word_ready = 1'b1;
    send(4'h5); send(4'h6); send(4'hB); send(4'hC);
    check("lat_early", 32'(bus.word_valid), 32'd0);
    step();
    check("lat_valid", 32'(bus.word_valid), 32'd1);
    check("basic_word", 32'(bus.word_out), 32'h56BC);
    step();
    check("basic_clear", 32'(bus.word_valid), 32'd0);
    check("basic_drop", 32'(bus.drop_err), 32'd0);

    // Backpressure: first word held, FIFO fills with 5..8
    bus.word_ready = 1'b0;
    for (int v = 1; v <= 8; v++) send(4'(v));
    step(); step();
    check("bp_full", 32'(bus.full), 32'd1);
    check("bp_count", 32'(bus.fifo_count), 32'd4);
    check("bp_valid", 32'(bus.word_valid), 32'd1);
    check("bp_word", 32'(bus.word_out), 32'h1234);

    // Overflow attempt while full
    bus.write_req = 1'b1;
    bus.in_data   = 4'hF;
    step();
    bus.write_req = 1'b0;
    step();
    check("ovf_drop", 32'(bus.drop_err), 32'd1);
    check("ovf_count", 32'(bus.fifo_count), 32'd4);
    check("ovf_word", 32'(bus.word_out), 32'h1234);

    bus.word_ready = 1'b1;
    for (int v = 9; v <= 12; v++) send(4'(v));
    drain(100);
    check("ovf_sticky", 32'(bus.drop_err), 32'd1);

    // Reset mid-packet
    send(4'hE); send(4'hF);
    reset = 1'b0;
    #1;
    check("midrst_count", 32'(bus.fifo_count), 32'd0);
    check("midrst_drop", 32'(bus.drop_err), 32'd0);
    check("midrst_valid", 32'(bus.word_valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    send(4'h5); send(4'h6); send(4'hB); send(4'hC);
    wait_valid("midrst_wait", 20);
    check("midrst_word", 32'(bus.word_out), 32'h56BC);
    step();

    // Gapped input
    send(4'h3); send(4'h4);
    for (int g = 0; g < 5; g++) begin
      step();
      check("gap_valid", 32'(bus.word_valid), 32'd0);
    end
    send(4'h7); send(4'h8);
    wait_valid("gap_wait", 20);
    check("gap_word", 32'(bus.word_out), 32'h3478);
    step();

    // Randomized run with random consumer readiness
    words0    = n_words;
    rnd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) step();
      send(4'($urandom_range(0, 15)));
    end
    rnd_ready      = 1'b0;
    bus.word_ready = 1'b1;
    drain(400);
    step();
    check("rnd_words", 32'(n_words - words0), 32'd10);
    check("rnd_count", 32'(bus.fifo_count), 32'd0);
    check("rnd_drop", 32'(bus.drop_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/local_port_rx.md
LOCAL_PORT_RX -- requirements
Module: local_port_rx

Interface
REQ-001 Parameter FLIT_W, default 4: flit data width in bits.
REQ-002 Parameter DEPTH, default 4: receive FIFO depth in flits; SHALL be a power of two and at least 2.
REQ-003 Parameter FPW, default 4: flits per assembled word; word width W = FLIT_W*FPW (16 by default).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  FLIT_W  flit from the router output port.
REQ-007 write_req  input  1  router output port offers in_data this cycle.
REQ-008 full  output  1  backpressure to the router; the router SHALL NOT be sent new flits while it is 1.
REQ-009 word_out  output  W  assembled word; the first-received flit occupies the MSBs.
REQ-010 word_valid  output  1  word_out holds a complete word.
REQ-011 word_ready  input  1  consumer accepts word_out.
REQ-012 drop_err  output  1  sticky flag: a write was attempted while full.
REQ-013 fifo_count  output  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 A flit SHALL be accepted on a rising edge where write_req=1 and full=0; it is written to the FIFO tail.
REQ-015 full SHALL equal (fifo_count==DEPTH), decoded from registered state with no combinational path from write_req.
REQ-016 A write attempt while full=1 SHALL NOT modify the FIFO, SHALL set drop_err, and drop_err SHALL stay 1 until reset.
REQ-017 There SHALL be no write-to-read bypass: a flit accepted at edge N is poppable no earlier than edge N+1.
REQ-018 Pointers SHALL wrap modulo DEPTH. A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-019 The assembler FSM SHALL have two states, COLLECT(idx 0..FPW-1) and HOLD.
REQ-020 In COLLECT with the FIFO non-empty: pop one flit per edge into nibble slot idx (slot 0 = MSBs), then increment idx.
REQ-021 On the pop with idx=FPW-1, the FSM SHALL enter HOLD and word_valid SHALL go to 1.
REQ-022 In HOLD: no pops; word_out and word_valid SHALL be held stable until word_ready=1.
REQ-023 On the edge where HOLD and word_ready=1: go to COLLECT idx=0 and clear word_valid. No pop SHALL occur on that edge.
REQ-024 In COLLECT with the FIFO empty: idx SHALL hold and partial word contents SHALL be retained.
REQ-025 Latency: 4 flits accepted on consecutive edges 0..3 into an empty block with an idle FSM SHALL produce word_valid=1 after edge 4.
REQ-026 Sustained throughput SHALL be FPW flits per FPW+1 cycles when word_ready is held at 1.
REQ-027 word_ready while word_valid=0 SHALL be ignored.

Reset
REQ-028 While reset=0, asynchronously: FIFO pointers and fifo_count = 0, full=0, FSM = COLLECT idx=0, word_out=0, word_valid=0, drop_err=0.
REQ-029 Reset asserted mid-packet or mid-HOLD SHALL discard all buffered and partial flits. The first flit accepted after release SHALL be word slot 0.
REQ-030 Deassertion of reset SHALL take effect on the next rising edge. No flit SHALL be accepted on an edge where reset=0.

Verification
REQ-031 Basic: word_ready=1; flits 5,6,B,C on consecutive edges -> word_out=0x56BC, word_valid=1 after edge 4, cleared after edge 5; drop_err=0.
REQ-032 Backpressure: word_ready=0; stream 12 flits 1..C with write_req held and honouring full.
  - Expected: word 0x1234 held in HOLD; FIFO holds 5..8; full=1, fifo_count=4.
  - Then word_ready=1 -> words 0x1234, 0x5678, 0x9ABC delivered in order.
REQ-033 Overflow: with full=1, drive write_req=1, in_data=F.
  - Expected: drop_err=1 (sticky); FIFO contents and count unchanged; F never appears in word_out.
REQ-034 Gapped input: flits 3,4 (idle 5 cycles) 7,8 -> word_out=0x3478; word_valid stays 0 during the gap.
REQ-035 Reset mid-packet: after flits E,F, assert reset for 1 cycle; then send 5,6,B,C -> word_out=0x56BC; fifo_count=0 and drop_err=0 immediately on reset assertion.
REQ-036 Wrap-around: run 40 flits with random word_ready -> all 10 words in order, fifo_count never exceeds DEPTH, drop_err=0.
